psum_glb_bank: RTL and testbench

- One GLB psum bank: buffering/accumulation storage directly behind the psum router's GLB-side ports.
- Write channel consumes the psums the router forwards from the PE; the stored value overwrites or accumulates into the bank.
- Read channel streams stored psums back to the router's GLB input, toward the PE or the south neighbour.
- One bank per GLB psum column; control comes from the cluster controller.

---
 rtl/psum_glb_bank.sv | 133 +++++++++++++
 tb/tb_psum_glb_bank.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_glb_bank.sv
// One GLB psum bank: a write channel that overwrites or saturating-accumulates
// router psums into storage, and a zero-bubble read channel that streams them back.
module psum_glb_bank #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_in_valid,
  output logic              wr_in_ready,
  input  logic [DATA_W-1:0] wr_in_data,
  output logic              rd_out_valid,
  input  logic              rd_out_ready,
  output logic [DATA_W-1:0] rd_out_data,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              cfg_acc,
  input  logic              wr_start,
  input  logic              rd_start,
  output logic              wr_done,
  output logic              rd_done
);

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_BUSY = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_BUSY = 1'b1;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [0:0]        wr_state;
  logic [0:0]        rd_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W-1:0] len_w;
  logic [ADDR_W-1:0] len_r;
  logic              acc;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              both_idle;
  logic              wr_go;
  logic              rd_go;
  logic              wr_fire;
  logic              wr_last;
  logic              rd_fire;
  logic              rd_last;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] wr_value;

  assign both_idle   = (wr_state == WR_IDLE) && (rd_state == RD_IDLE);
  // Write has priority when both starts arrive together.
  assign wr_go       = wr_start && both_idle;
  assign rd_go       = rd_start && both_idle && !wr_start;
  assign wr_in_ready = (wr_state == WR_BUSY);
  assign wr_fire     = wr_in_ready && wr_in_valid;
  assign wr_last     = wr_fire && (wr_ptr == len_w);
  assign rd_fire     = (rd_state == RD_BUSY) && rd_out_valid && rd_out_ready;
  assign rd_last     = rd_fire && (rd_ptr == len_r);
  assign rd_next     = rd_ptr + 1'b1;

  // One extra bit of headroom; overflow shows up as disagreeing top two bits.
  always_comb begin
    sum = {mem[wr_ptr][DATA_W-1], mem[wr_ptr]} + {wr_in_data[DATA_W-1], wr_in_data};
    if (!acc) begin
      wr_value = wr_in_data;
    end else if (sum[DATA_W] != sum[DATA_W-1]) begin
      wr_value = sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      wr_value = sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      wr_ptr   <= '0;
      len_w    <= '0;
      acc      <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      if (wr_go) begin
        wr_state <= WR_BUSY;
        wr_ptr   <= '0;
        len_w    <= cfg_len;
        acc      <= cfg_acc;
      end else if (wr_last) begin
        wr_state <= WR_IDLE;
        wr_done  <= 1'b1;
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Output register is preloaded with the next entry on every accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state     <= RD_IDLE;
      rd_ptr       <= '0;
      len_r        <= '0;
      rd_out_valid <= 1'b0;
      rd_out_data  <= '0;
      rd_done      <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (rd_go) begin
        rd_state     <= RD_BUSY;
        rd_ptr       <= '0;
        len_r        <= cfg_len;
        rd_out_valid <= 1'b1;
        rd_out_data  <= mem[0];
      end else if (rd_last) begin
        rd_state     <= RD_IDLE;
        rd_out_valid <= 1'b0;
        rd_done      <= 1'b1;
      end else if (rd_fire) begin
        rd_ptr      <= rd_next;
        rd_out_data <= mem[rd_next];
      end
    end
  end

endmodule

// File: tb/tb_psum_glb_bank.sv
// Self-checking bench for psum_glb_bank: directed scenarios plus random passes
// checked against an array model of the bank with saturating accumulate.
module tb_psum_glb_bank;

  localparam int MAX_VAL = 1048575;
  localparam int MIN_VAL = -1048576;

  logic               clk;
  logic               reset;
  logic               wr_in_valid;
  logic               wr_in_ready;
  logic signed [20:0] wr_in_data;
  logic               rd_out_valid;
  logic               rd_out_ready;
  logic signed [20:0] rd_out_data;
  logic [4:0]         cfg_len;
  logic               cfg_acc;
  logic               wr_start;
  logic               rd_start;
  logic               wr_done;
  logic               rd_done;

  int checks;
  int failures;
  int model [32];
  bit known [32];
  int wr_q [$];
  bit rdy_q [$];

  psum_glb_bank dut (
    .clk          (clk),
    .reset        (reset),
    .wr_in_valid  (wr_in_valid),
    .wr_in_ready  (wr_in_ready),
    .wr_in_data   (wr_in_data),
    .rd_out_valid (rd_out_valid),
    .rd_out_ready (rd_out_ready),
    .rd_out_data  (rd_out_data),
    .cfg_len      (cfg_len),
    .cfg_acc      (cfg_acc),
    .wr_start     (wr_start),
    .rd_start     (rd_start),
    .wr_done      (wr_done),
    .rd_done      (rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int sat(input int v);
    if (v > MAX_VAL) return MAX_VAL;
    if (v < MIN_VAL) return MIN_VAL;
    return v;
  endfunction

  function automatic int rand_psum();
    return int'($urandom_range(0, 2097151)) - 1048576;
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic write_pass(input int len, input bit acc, input bit gaps,
                            input bit also_rd, input bit poke);
    int beat;
    int cycles;
    int d;
    bit poked;
    beat = 0;
    cycles = 0;
    poked = 0;
    @(negedge clk);
    cfg_len = 5'(len);
    cfg_acc = acc;
    wr_start = 1'b1;
    rd_start = also_rd;
    @(negedge clk);
    wr_start = 1'b0;
    rd_start = 1'b0;
    while (beat <= len && cycles < 400) begin
      checkOutput("wr_ready_busy", wr_in_ready, 1);
      checkOutput("wr_done_early", wr_done, 0);
      checkOutput("rd_valid_during_wr", rd_out_valid, 0);
      if (poke && !poked && beat == 1) begin
        wr_start = 1'b1;
        rd_start = 1'b1;
        cfg_len = 5'd0;
        cfg_acc = ~acc;
        poked = 1;
      end
      if (!gaps || $urandom_range(0, 3) != 0) begin
        d = (wr_q.size() > 0) ? wr_q.pop_front() : rand_psum();
        wr_in_valid = 1'b1;
        wr_in_data = 21'(d);
        model[beat] = acc ? sat(model[beat] + d) : d;
        known[beat] = 1;
        beat++;
      end else begin
        wr_in_valid = 1'b0;
      end
      @(negedge clk);
      cycles++;
      wr_start = 1'b0;
      rd_start = 1'b0;
    end
    wr_in_valid = 1'b0;
    if (!gaps) checkOutput("wr_cycles", cycles, len + 1);
    checkOutput("wr_done", wr_done, 1);
    checkOutput("wr_ready_idle", wr_in_ready, 0);
    checkOutput("rd_valid_after_wr", rd_out_valid, 0);
    @(negedge clk);
    checkOutput("wr_done_once", wr_done, 0);
  endtask

  task automatic read_pass(input int len, input bit rand_ready);
    int idx;
    int cycles;
    int exp_cycles;
    bit rdy;
    idx = 0;
    cycles = 0;
    exp_cycles = (rdy_q.size() > 0) ? rdy_q.size() : (rand_ready ? -1 : len + 1);
    @(negedge clk);
    cfg_len = 5'(len);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    while (idx <= len && cycles < 400) begin
      checkOutput("rd_valid", rd_out_valid, 1);
      checkOutput($sformatf("rd_data[%0d]", idx), rd_out_data, model[idx]);
      checkOutput("rd_done_early", rd_done, 0);
      checkOutput("wr_ready_during_rd", wr_in_ready, 0);
      if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
      else rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      rd_out_ready = rdy;
      if (rdy) idx++;
      @(negedge clk);
      cycles++;
    end
    rd_out_ready = 1'b0;
    if (exp_cycles >= 0) checkOutput("rd_cycles", cycles, exp_cycles);
    checkOutput("rd_done", rd_done, 1);
    checkOutput("rd_valid_end", rd_out_valid, 0);
    @(negedge clk);
    checkOutput("rd_done_once", rd_done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_wr_ready"}, wr_in_ready, 0);
    checkOutput({tag, "_rd_valid"}, rd_out_valid, 0);
    checkOutput({tag, "_rd_data"}, rd_out_data, 0);
    checkOutput({tag, "_wr_done"}, wr_done, 0);
    checkOutput({tag, "_rd_done"}, rd_done, 0);
  endtask

  initial begin
    int len;
    int rlen;
    bit acc;
    int hi;
    checks = 0;
    failures = 0;
    hi = -1;
    for (int i = 0; i < 32; i++) begin
      model[i] = 0;
      known[i] = 0;
    end
    reset = 1'b1;
    wr_in_valid = 1'b0;
    wr_in_data = '0;
    rd_out_ready = 1'b0;
    cfg_len = '0;
    cfg_acc = 1'b0;
    wr_start = 1'b0;
    rd_start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    $display("[TB] overwrite and accumulate passes");
    wr_q = '{10, -20, 30, -40};
    write_pass(3, 0, 0, 0, 0);
    read_pass(3, 0);
    wr_q = '{5, 5, 5, 5};
    write_pass(3, 1, 0, 0, 0);
    read_pass(3, 0);

    $display("[TB] saturation");
    wr_q = '{1048000};
    write_pass(0, 0, 0, 0, 0);
    wr_q = '{1000};
    write_pass(0, 1, 0, 0, 0);
    read_pass(0, 0);
    checkOutput("sat_hi_model", model[0], MAX_VAL);
    wr_q = '{-1048000};
    write_pass(0, 0, 0, 0, 0);
    wr_q = '{-1000};
    write_pass(0, 1, 0, 0, 0);
    read_pass(0, 0);

    $display("[TB] backpressure");
    rdy_q = '{1, 0, 0, 1, 0, 1, 1};
    read_pass(3, 0);

    $display("[TB] start conflicts");
    write_pass(2, 0, 0, 1, 0);
    read_pass(2, 0);
    write_pass(3, 1, 1, 0, 1);
    read_pass(3, 1);

    $display("[TB] full depth and random passes");
    write_pass(31, 0, 1, 0, 0);
    read_pass(31, 1);
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(0, 31);
      acc = 1'($urandom_range(0, 1));
      write_pass(len, acc, 1, 0, 0);
      rlen = $urandom_range(0, 31);
      read_pass(rlen, 1);
    end

    $display("[TB] reset mid write pass");
    @(negedge clk);
    cfg_len = 5'd3;
    cfg_acc = 1'b0;
    wr_start = 1'b1;
    @(negedge clk);
    wr_start = 1'b0;
    wr_in_valid = 1'b1;
    wr_in_data = 21'sd111;
    model[0] = 111;
    @(negedge clk);
    wr_in_data = -21'sd222;
    model[1] = -222;
    @(negedge clk);
    wr_in_data = 21'sd333;
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset_wr");
    @(negedge clk);
    reset = 1'b0;
    wr_in_data = 21'sd999;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("no_wr_done_after_reset", wr_done, 0);
      checkOutput("idle_ready_low", wr_in_ready, 0);
    end
    wr_in_valid = 1'b0;
    wr_q = '{444};
    write_pass(0, 0, 0, 0, 0);
    read_pass(3, 0);

    $display("[TB] reset mid read pass");
    @(negedge clk);
    cfg_len = 5'd3;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    rd_out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rd_data_before_reset", rd_out_data, model[1]);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset_rd");
    rd_out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("no_rd_done_after_reset", rd_done, 0);
      checkOutput("rd_valid_after_reset", rd_out_valid, 0);
    end
    for (int i = 0; i < 32; i++) if (known[i]) hi = i;
    read_pass(hi < 3 ? hi : 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
